// File: rtl/mem_responder_if.sv
// Core-side request/response bundle between cpu_core (master) and mem_responder (slave).
interface mem_responder_if;
    logic [1:0]  rw_flag;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic [31:0] read_data;
    logic        busy;
    logic        done;

    modport master (
        output rw_flag, addr, write_data, write_mask,
        input  read_data, busy, done
    );

    modport slave (
        input  rw_flag, addr, write_data, write_mask,
        output read_data, busy, done
    );
endinterface

// File: rtl/mem_responder.sv
// Serialises one word request onto a byte-wide synchronous RAM port and reassembles reads.
// Optional MEM_RESP_ALIGN_ERR_EN: rejects unaligned requests and reports them on err.
module mem_responder #(
    parameter int unsigned ADDR_BITS = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_responder_if.slave       bus,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    output logic                 ram_we,
    input  logic [7:0]           ram_rdata
`ifdef MEM_RESP_ALIGN_ERR_EN
    ,
    output logic                 err
`endif
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             rem_q, rem_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [23:0]            rbuf_q, rbuf_d;
    logic [31:0]            read_data_q, read_data_d;
    logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]             ram_wdata_q, ram_wdata_d;
    logic                   ram_we_q, ram_we_d;
`ifdef MEM_RESP_ALIGN_ERR_EN
    logic                   err_q, err_d;
`endif

    logic                   req_valid;
    logic [3:0]             pick_mask;
    logic [31:0]            pick_data;
    logic [ADDR_BITS-1:0]   pick_base;
    logic [1:0]             pick_idx;
    logic [3:0]             pick_rest;
    logic [31:0]            pick_shift;
    logic [7:0]             pick_byte;
    logic [ADDR_BITS-1:0]   pick_addr;
    logic                   unused_addr;

    assign unused_addr = ^bus.addr[31:ADDR_BITS];
    assign req_valid   = (bus.rw_flag == 2'b01) || (bus.rw_flag == 2'b10);

    // Lowest pending write byte: taken from the live request in IDLE, else from the latched copy.
    always_comb begin
        pick_mask = (state_q == StIdle) ? bus.write_mask : rem_q;
        pick_data = (state_q == StIdle) ? bus.write_data : wdata_q;
        pick_base = (state_q == StIdle) ? bus.addr[ADDR_BITS-1:0] : base_q;
        pick_idx  = 2'd0;
        if (pick_mask[0])      pick_idx = 2'd0;
        else if (pick_mask[1]) pick_idx = 2'd1;
        else if (pick_mask[2]) pick_idx = 2'd2;
        else if (pick_mask[3]) pick_idx = 2'd3;
        pick_rest  = pick_mask & ~(4'b0001 << pick_idx);
        pick_shift = pick_data >> {pick_idx, 3'b000};
        pick_byte  = pick_shift[7:0];
        pick_addr  = pick_base + ADDR_BITS'(pick_idx);
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        read_data_d = read_data_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
`ifdef MEM_RESP_ALIGN_ERR_EN
        err_d       = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    base_d  = bus.addr[ADDR_BITS-1:0];
                    wdata_d = bus.write_data;
                    cnt_d   = 3'd0;
`ifdef MEM_RESP_ALIGN_ERR_EN
                    err_d   = 1'b0;
                    if (bus.addr[1:0] != 2'b00) begin
                        // Empty write pass gives the one-cycle turnaround with no RAM access.
                        state_d     = StWr;
                        rem_d       = 4'b0000;
                        read_data_d = 32'h0;
                        err_d       = 1'b1;
                    end else
`endif
                    if (bus.rw_flag == 2'b01) begin
                        state_d    = StRd;
                        ram_addr_d = bus.addr[ADDR_BITS-1:0];
                    end else begin
                        state_d = StWr;
                        rem_d   = pick_rest;
                        if (pick_mask != 4'b0000) begin
                            ram_we_d    = 1'b1;
                            ram_addr_d  = pick_addr;
                            ram_wdata_d = pick_byte;
                        end
                    end
                end
            end
            StRd: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < 3'd3) ram_addr_d = base_q + ADDR_BITS'(cnt_q + 3'd1);
                // RAM answers one cycle after the address, so byte k lands at count k+1.
                case (cnt_q)
                    3'd1: rbuf_d[7:0]   = ram_rdata;
                    3'd2: rbuf_d[15:8]  = ram_rdata;
                    3'd3: rbuf_d[23:16] = ram_rdata;
                    3'd4: begin
                        read_data_d = {ram_rdata, rbuf_q};
                        state_d     = StDone;
                    end
                    default: ;
                endcase
            end
            StWr: begin
                if (rem_q != 4'b0000) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = pick_addr;
                    ram_wdata_d = pick_byte;
                    rem_d       = pick_rest;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef MEM_RESP_ALIGN_ERR_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            wdata_q     <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            read_data_q <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
`ifdef MEM_RESP_ALIGN_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            rbuf_q      <= rbuf_d;
            read_data_q <= read_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
`ifdef MEM_RESP_ALIGN_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    assign bus.busy      = (state_q == StRd) || (state_q == StWr);
    assign bus.done      = (state_q == StDone);
    assign bus.read_data = read_data_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_we        = ram_we_q;
`ifdef MEM_RESP_ALIGN_ERR_EN
    assign err           = err_q && (state_q == StDone);
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a byte-wide synchronous RAM model and read scoreboard.
module tb_mem_responder;

    localparam int unsigned AB = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AB-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_rdata = 8'h00;
`ifdef MEM_RESP_ALIGN_ERR_EN
    logic          err;
    logic          last_err;
`endif

    mem_responder_if bus ();

    mem_responder #(.ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
`ifdef MEM_RESP_ALIGN_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]    mem [0:(1<<AB)-1] = '{default: 8'h00};
    logic [AB-1:0] wr_addr_log [$];
    logic [7:0]    wr_data_log [$];

    // Synchronous RAM; the preload is applied while reset is held.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (rst) begin
            mem[17'h100] <= 8'h78;
            mem[17'h101] <= 8'h56;
            mem[17'h102] <= 8'h34;
            mem[17'h103] <= 8'h12;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_addr_log.push_back(ram_addr);
            wr_data_log.push_back(ram_wdata);
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rd [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until done is seen, return latency in edges after acceptance.
    task automatic do_req(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int lat, output logic busy0,
                          output logic [31:0] rd, output logic pulse_ok);
        @(negedge clk);
        bus.rw_flag    = rw;
        bus.addr       = a;
        bus.write_data = d;
        bus.write_mask = m;
        @(posedge clk);
        @(negedge clk);
        busy0 = bus.busy;
        lat   = 0;
        while (!bus.done && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = bus.read_data;
`ifdef MEM_RESP_ALIGN_ERR_EN
        last_err = err;
`endif
        bus.rw_flag = 2'b00;
        @(negedge clk);
        pulse_ok = !bus.done;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        busy0;
        logic        pulse_ok;
        logic [31:0] rd;
        int          wbase;
        logic [AB-1:0] exp_a [4];
        logic [7:0]    exp_d [4];

        bus.rw_flag    = 2'b00;
        bus.addr       = 32'h0;
        bus.write_data = 32'h0;
        bus.write_mask = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", {bus.busy, bus.done, ram_we, bus.read_data}, 64'h0);
        end

        // Read 0x100
        wbase = wr_addr_log.size();
        exp_rd.push_back(32'h1234_5678);
        do_req(2'b01, 32'h100, 32'h0, 4'h0, lat, busy0, rd, pulse_ok);
        check("rd100_latency", lat, 5);
        check("rd100_busy", busy0, 1'b1);
        check("rd100_data", rd, exp_rd.pop_front());
        check("rd100_pulse", pulse_ok, 1'b1);
        check("rd100_no_we", wr_addr_log.size() - wbase, 0);
`ifdef MEM_RESP_ALIGN_ERR_EN
        check("rd100_err", last_err, 1'b0);
`endif

        // Masked write 0101
        wbase = wr_addr_log.size();
        do_req(2'b10, 32'h200, 32'hAABB_CCDD, 4'b0101, lat, busy0, rd, pulse_ok);
        check("wr0101_latency", lat, 2);
        check("wr0101_rd_hold", rd, 32'h1234_5678);
        check("wr0101_count", wr_addr_log.size() - wbase, 2);
        if (wr_addr_log.size() - wbase == 2) begin
            check("wr0101_a0", wr_addr_log[wbase], 17'h200);
            check("wr0101_d0", wr_data_log[wbase], 8'hDD);
            check("wr0101_a1", wr_addr_log[wbase+1], 17'h202);
            check("wr0101_d1", wr_data_log[wbase+1], 8'hBB);
        end

        exp_rd.push_back(32'h00BB_00DD);
        do_req(2'b01, 32'h200, 32'h0, 4'h0, lat, busy0, rd, pulse_ok);
        check("rd200_latency", lat, 5);
        check("rd200_data", rd, exp_rd.pop_front());

        // Empty mask write
        wbase = wr_addr_log.size();
        do_req(2'b10, 32'h300, 32'hFFFF_FFFF, 4'b0000, lat, busy0, rd, pulse_ok);
        check("wr0000_latency", lat, 1);
        check("wr0000_no_we", wr_addr_log.size() - wbase, 0);
        check("wr0000_pulse", pulse_ok, 1'b1);

`ifndef MEM_RESP_ALIGN_ERR_EN
        // Full write across the top of RAM; upper request address bits are dropped
        wbase = wr_addr_log.size();
        do_req(2'b10, 32'hF001_FFFE, 32'h4433_2211, 4'b1111, lat, busy0, rd, pulse_ok);
        check("wr1111_latency", lat, 4);
        check("wr1111_count", wr_addr_log.size() - wbase, 4);
        exp_a = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        if (wr_addr_log.size() - wbase == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("wr1111_addr", wr_addr_log[wbase+k], exp_a[k]);
                check("wr1111_data", wr_data_log[wbase+k], exp_d[k]);
            end
        end
        exp_rd.push_back(32'h4433_2211);
        do_req(2'b01, 32'h1FFFE, 32'h0, 4'h0, lat, busy0, rd, pulse_ok);
        check("rdwrap_data", rd, exp_rd.pop_front());
`else
        // Unaligned read rejected
        wbase = wr_addr_log.size();
        do_req(2'b01, 32'h101, 32'h0, 4'h0, lat, busy0, rd, pulse_ok);
        check("unal_latency", lat, 1);
        check("unal_err", last_err, 1'b1);
        check("unal_data", rd, 32'h0);
        check("unal_no_we", wr_addr_log.size() - wbase, 0);
        do_req(2'b10, 32'h102, 32'hFFFF_FFFF, 4'b1111, lat, busy0, rd, pulse_ok);
        check("unal_wr_err", last_err, 1'b1);
        check("unal_wr_no_we", wr_addr_log.size() - wbase, 0);
`endif

        // Reset during a read, after E2
        @(negedge clk);
        bus.rw_flag = 2'b01;
        bus.addr    = 32'h100;
        @(posedge clk);
        @(negedge clk);
        bus.rw_flag = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_rd_outputs", {bus.busy, bus.done, ram_we, bus.read_data}, 64'h0);
        check("rst_rd_addr", ram_addr, 17'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during a write drops ram_we without a clock edge
        @(negedge clk);
        bus.rw_flag    = 2'b10;
        bus.addr       = 32'h400;
        bus.write_data = 32'h0102_0304;
        bus.write_mask = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        bus.rw_flag = 2'b00;
        check("wr_we_active", ram_we, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_wr_we", ram_we, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        exp_rd.push_back(32'h1234_5678);
        do_req(2'b01, 32'h100, 32'h0, 4'h0, lat, busy0, rd, pulse_ok);
        check("rd_after_rst_latency", lat, 5);
        check("rd_after_rst_data", rd, exp_rd.pop_front());
        check("rd_after_rst_pulse", pulse_ok, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
